// File: rtl/multicycle_main_fsm.sv
// Multicycle ARM main control FSM.
// Sequences FETCH/DECODE/execute states and produces unconditioned write
// intents (gated later by the conditional-logic stage), datapath selects and
// ALU control. Moore outputs are decoded from the registered state; write
// strobes are forced low while reset is asserted.
module multicycle_main_fsm #(
  parameter int unsigned MEM_LAT = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  output logic       PCS,
  output logic       RegW,
  output logic       MemW,
  output logic [1:0] FlagW,
  output logic       NoWrite,
  output logic       NextPC,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic [1:0] ResultSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUControl,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic       illegal_op,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9
  } state_t;

  localparam logic [3:0] MEM_LAT_C = 4'(MEM_LAT);

  state_t     state_r;
  logic [3:0] wait_cnt_r;
  logic       nowrite_r;

  logic [1:0] alu_ctrl_s;
  logic [1:0] alu_flagw_s;
  logic       alu_nowrite_s;
  logic       rd_is_pc_s;

  assign rd_is_pc_s = (Rd == 4'd15);
  assign ImmSrc     = Op;
  assign RegSrc     = {(Op == 2'b01), (Op == 2'b10)};
  assign state_o    = state_r;

  // ALU command decode: operation, flag-write mask and CMP write suppression
  always_comb begin
    alu_ctrl_s    = 2'b00;
    alu_flagw_s   = 2'b00;
    alu_nowrite_s = 1'b0;
    case (Funct[4:1])
      4'b0100: begin
        alu_ctrl_s  = 2'b00;
        alu_flagw_s = Funct[0] ? 2'b11 : 2'b00;
      end
      4'b0010: begin
        alu_ctrl_s  = 2'b01;
        alu_flagw_s = Funct[0] ? 2'b11 : 2'b00;
      end
      4'b0000: begin
        alu_ctrl_s  = 2'b10;
        alu_flagw_s = Funct[0] ? 2'b10 : 2'b00;
      end
      4'b1100: begin
        alu_ctrl_s  = 2'b11;
        alu_flagw_s = Funct[0] ? 2'b10 : 2'b00;
      end
      4'b1010: begin
        // CMP: subtract, always update all flags, never write Rd
        alu_ctrl_s    = 2'b01;
        alu_flagw_s   = 2'b11;
        alu_nowrite_s = 1'b1;
      end
      default: begin
        alu_ctrl_s  = 2'b00;
        alu_flagw_s = 2'b00;
      end
    endcase
  end

  // State register, MEMREAD wait counter and NoWrite carried into ALUWB
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= S_FETCH;
      wait_cnt_r <= 4'd0;
      nowrite_r  <= 1'b0;
    end else begin
      case (state_r)
        S_FETCH: state_r <= S_DECODE;
        S_DECODE: begin
          case (Op)
            2'b00:   state_r <= Funct[5] ? S_EXECUTEI : S_EXECUTER;
            2'b01:   state_r <= S_MEMADR;
            2'b10:   state_r <= S_BRANCH;
            default: state_r <= S_FETCH;
          endcase
        end
        S_MEMADR: state_r <= Funct[0] ? S_MEMREAD : S_MEMWRITE;
        S_MEMREAD: begin
          if (wait_cnt_r == MEM_LAT_C) begin
            state_r    <= S_MEMWB;
            wait_cnt_r <= 4'd0;
          end else begin
            wait_cnt_r <= wait_cnt_r + 4'd1;
          end
        end
        S_EXECUTER, S_EXECUTEI: begin
          state_r   <= S_ALUWB;
          nowrite_r <= alu_nowrite_s;
        end
        S_MEMWB, S_MEMWRITE, S_ALUWB, S_BRANCH: state_r <= S_FETCH;
        default: state_r <= S_FETCH;
      endcase
    end
  end

  // Moore output decode; write strobes are held low while reset is high
  always_comb begin
    PCS        = 1'b0;
    RegW       = 1'b0;
    MemW       = 1'b0;
    FlagW      = 2'b00;
    NoWrite    = 1'b0;
    NextPC     = 1'b0;
    IRWrite    = 1'b0;
    AdrSrc     = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUControl = 2'b00;
    illegal_op = 1'b0;
    case (state_r)
      S_FETCH: begin
        IRWrite   = 1'b1;
        NextPC    = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      S_DECODE: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        ResultSrc  = 2'b10;
        illegal_op = (Op == 2'b11);
      end
      S_MEMADR: begin
        ALUSrcB = 2'b01;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegW      = 1'b1;
        PCS       = rd_is_pc_s;
      end
      S_MEMWRITE: begin
        AdrSrc = 1'b1;
        MemW   = 1'b1;
      end
      S_EXECUTER, S_EXECUTEI: begin
        ALUSrcB    = (state_r == S_EXECUTEI) ? 2'b01 : 2'b00;
        ALUControl = alu_ctrl_s;
        FlagW      = alu_flagw_s;
        NoWrite    = alu_nowrite_s;
      end
      S_ALUWB: begin
        RegW    = 1'b1;
        PCS     = rd_is_pc_s;
        NoWrite = nowrite_r;
      end
      S_BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        PCS       = 1'b1;
      end
      default: begin
        PCS = 1'b0;
      end
    endcase
    if (reset) begin
      PCS        = 1'b0;
      RegW       = 1'b0;
      MemW       = 1'b0;
      FlagW      = 2'b00;
      NoWrite    = 1'b0;
      NextPC     = 1'b0;
      IRWrite    = 1'b0;
      illegal_op = 1'b0;
    end else begin
      illegal_op = illegal_op;
    end
  end

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// Self-checking bench for multicycle_main_fsm. Each instruction is expanded
// into the list of per-cycle control vectors it should produce, and the DUT
// is compared cycle by cycle against that list.
module tb_multicycle_main_fsm;

  localparam int unsigned LAT = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic       PCS, RegW, MemW, NoWrite, NextPC, IRWrite, AdrSrc, ALUSrcA, illegal_op;
  logic [1:0] FlagW, ResultSrc, ALUSrcB, ALUControl, ImmSrc, RegSrc;
  logic [3:0] state_o;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [3:0] st;
    logic       irw;
    logic       npc;
    logic       adrsrc;
    logic [1:0] ressrc;
    logic       srca;
    logic [1:0] srcb;
    logic [1:0] aluc;
    logic [1:0] flagw;
    logic       pcs;
    logic       regw;
    logic       memw;
    logic       nowr;
    logic       ill;
  } vec_t;

  vec_t exp_q[$];

  multicycle_main_fsm #(.MEM_LAT(LAT)) dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd),
    .PCS(PCS), .RegW(RegW), .MemW(MemW), .FlagW(FlagW), .NoWrite(NoWrite),
    .NextPC(NextPC), .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
    .ImmSrc(ImmSrc), .RegSrc(RegSrc), .illegal_op(illegal_op), .state_o(state_o)
  );

  always #5 clk = ~clk;

  function automatic vec_t observed();
    vec_t o;
    o = '{st: state_o, irw: IRWrite, npc: NextPC, adrsrc: AdrSrc, ressrc: ResultSrc,
          srca: ALUSrcA, srcb: ALUSrcB, aluc: ALUControl, flagw: FlagW, pcs: PCS,
          regw: RegW, memw: MemW, nowr: NoWrite, ill: illegal_op};
    return o;
  endfunction

  // Reference: list of control vectors an instruction produces, one per cycle
  task automatic expand(input logic [1:0] op, input logic [5:0] funct, input logic [3:0] rd);
    vec_t v;
    logic [3:0] cmd;
    logic is_add, is_sub, is_and, is_orr, is_cmp;
    exp_q.delete();
    v = '0; v.st = 4'd0; v.irw = 1'b1; v.npc = 1'b1; v.srca = 1'b1; v.srcb = 2'b10; v.ressrc = 2'b10;
    exp_q.push_back(v);
    v = '0; v.st = 4'd1; v.srca = 1'b1; v.srcb = 2'b10; v.ressrc = 2'b10; v.ill = (op == 2'b11);
    exp_q.push_back(v);
    if (op == 2'b01) begin
      v = '0; v.st = 4'd2; v.srcb = 2'b01;
      exp_q.push_back(v);
      if (funct[0]) begin
        for (int i = 0; i <= int'(LAT); i++) begin
          v = '0; v.st = 4'd3; v.adrsrc = 1'b1;
          exp_q.push_back(v);
        end
        v = '0; v.st = 4'd4; v.ressrc = 2'b01; v.regw = 1'b1; v.pcs = (rd == 4'd15);
        exp_q.push_back(v);
      end else begin
        v = '0; v.st = 4'd5; v.adrsrc = 1'b1; v.memw = 1'b1;
        exp_q.push_back(v);
      end
    end else if (op == 2'b00) begin
      cmd = funct[4:1];
      is_add = (cmd == 4'b0100); is_sub = (cmd == 4'b0010);
      is_and = (cmd == 4'b0000); is_orr = (cmd == 4'b1100); is_cmp = (cmd == 4'b1010);
      v = '0;
      v.st   = funct[5] ? 4'd7 : 4'd6;
      v.srcb = funct[5] ? 2'b01 : 2'b00;
      v.aluc = (is_sub || is_cmp) ? 2'b01 : is_and ? 2'b10 : is_orr ? 2'b11 : 2'b00;
      v.flagw = is_cmp ? 2'b11 : !funct[0] ? 2'b00 : (is_add || is_sub) ? 2'b11 :
                (is_and || is_orr) ? 2'b10 : 2'b00;
      v.nowr = is_cmp;
      exp_q.push_back(v);
      v = '0; v.st = 4'd8; v.regw = 1'b1; v.pcs = (rd == 4'd15); v.nowr = is_cmp;
      exp_q.push_back(v);
    end else if (op == 2'b10) begin
      v = '0; v.st = 4'd9; v.srcb = 2'b01; v.ressrc = 2'b10; v.pcs = 1'b1;
      exp_q.push_back(v);
    end
  endtask

  task automatic check_cycle(input vec_t e, input string tag);
    vec_t o;
    logic [3:0] sel_exp;
    o = observed();
    n_checks++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s ctrl observed=%h expected=%h", tag, o, e);
    end
    sel_exp = {Op, (Op == 2'b01), (Op == 2'b10)};
    n_checks++;
    assert ({ImmSrc, RegSrc} === sel_exp) else begin
      n_fail++;
      $error("FAIL %s_sel observed=%h expected=%h", tag, {ImmSrc, RegSrc}, sel_exp);
    end
  endtask

  task automatic check_reset(input logic [3:0] st_exp, input string tag);
    logic [8:0] strobes;
    strobes = {IRWrite, NextPC, PCS, RegW, MemW, FlagW, NoWrite, illegal_op};
    n_checks++;
    assert (strobes === 9'd0) else begin
      n_fail++;
      $error("FAIL %s_strobes observed=%h expected=%h", tag, strobes, 9'd0);
    end
    n_checks++;
    assert (state_o === st_exp) else begin
      n_fail++;
      $error("FAIL %s_state observed=%0d expected=%0d", tag, state_o, st_exp);
    end
  endtask

  // Called one time unit after a rising edge with the DUT in FETCH; leaves the
  // bench one time unit after the edge that ends the last checked cycle.
  task automatic run_instr(input logic [1:0] op, input logic [5:0] funct,
                           input logic [3:0] rd, input int ncyc, input string name);
    int n;
    Op = op; Funct = funct; Rd = rd;
    expand(op, funct, rd);
    n = (ncyc < 0) ? exp_q.size() : ncyc;
    for (int i = 0; i < n; i++) begin
      #1;
      check_cycle(exp_q[i], $sformatf("%s_c%0d", name, i));
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [3:0] cmds[5];
    logic [1:0] rop;
    logic [5:0] rfn;
    logic [3:0] rrd;
    cmds[0] = 4'b0100; cmds[1] = 4'b0010; cmds[2] = 4'b0000;
    cmds[3] = 4'b1100; cmds[4] = 4'b1010;

    reset = 1'b1; Op = 2'b00; Funct = 6'd0; Rd = 4'd0;
    @(posedge clk); #2;
    check_reset(4'd0, "reset0");
    @(posedge clk); #2;
    check_reset(4'd0, "reset1");
    @(posedge clk); #1;
    reset = 1'b0;

    // ADD Rd=3, S=1, register operand
    run_instr(2'b00, {1'b0, 4'b0100, 1'b1}, 4'd3, -1, "add");
    // CMP with S=1
    run_instr(2'b00, {1'b0, 4'b1010, 1'b1}, 4'd2, -1, "cmp");
    // LDR to PC
    run_instr(2'b01, 6'b000001, 4'd15, -1, "ldr_pc");
    // STR
    run_instr(2'b01, 6'b000000, 4'd4, -1, "str");
    // Branch
    run_instr(2'b10, 6'b000000, 4'd0, -1, "b");
    // Illegal opcode
    run_instr(2'b11, 6'b111111, 4'd15, -1, "illegal");
    // ORR immediate, S=1, Rd=15
    run_instr(2'b00, {1'b1, 4'b1100, 1'b1}, 4'd15, -1, "orri");

    // Reset arriving in the middle of MEMREAD (counter already advanced)
    run_instr(2'b01, 6'b000001, 4'd5, 5, "ldr_part");
    reset = 1'b1;
    #1;
    check_reset(4'd3, "midrst_pre");
    @(posedge clk); #2;
    check_reset(4'd0, "midrst_a");
    @(posedge clk); #2;
    check_reset(4'd0, "midrst_b");
    @(posedge clk); #1;
    reset = 1'b0;
    // full LDR afterwards must still wait exactly LAT+1 cycles in MEMREAD
    run_instr(2'b01, 6'b000001, 4'd7, -1, "ldr_after_rst");

    // Randomized instruction stream
    for (int k = 0; k < 60; k++) begin
      rop = 2'($urandom_range(0, 3));
      rfn = 6'($urandom);
      if ($urandom_range(0, 3) != 0) rfn[4:1] = cmds[$urandom_range(0, 4)];
      rrd = 4'($urandom);
      if ($urandom_range(0, 3) == 0) rrd = 4'd15;
      run_instr(rop, rfn, rrd, -1, $sformatf("rnd%0d", k));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
